io_mmio_ctrl: RTL and testbench

//  Memory-mapped I/O controller between the CPU memory stage and the on-chip UART plus perf counters.

---
 rtl/io_mmio_pkg.sv | 22 ++
 rtl/io_sync_fifo.sv | 67 ++++++
 rtl/io_mmio_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_io_mmio_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_mmio_pkg.sv
// Shared constants for the MMIO controller: register offsets, status bit
// positions, the default address-space selector and the TX FSM state type.
package io_mmio_pkg;

  localparam logic [3:0] IO_BASE_DEFAULT = 4'h8;

  localparam logic [7:0] OFS_STATUS = 8'h00;
  localparam logic [7:0] OFS_RXD    = 8'h04;
  localparam logic [7:0] OFS_TXD    = 8'h08;
  localparam logic [7:0] OFS_CYC    = 8'h10;
  localparam logic [7:0] OFS_INST   = 8'h14;
  localparam logic [7:0] OFS_CLR    = 8'h18;

  localparam int STAT_TX_FREE  = 0;
  localparam int STAT_RX_AVAIL = 1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO used as the UART RX buffer when IO_RX_FIFO_EN is defined.
// Push is ignored when full and pop is ignored when empty, so a simultaneous
// push+pop on a full FIFO performs only the pop. DEPTH must be a power of 2,
// which lets the pointers wrap naturally.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO controller between the CPU memory stage and the UART / perf counters.
// Loads return data one cycle after io_re, like dmem/bios.
// Optional build macro: IO_RX_FIFO_EN selects an RX_FIFO_DEPTH-entry RX FIFO
// instead of the single RX holding register.
//
// Handshakes (UART TX and RX): a transfer happens on a cycle where valid and
// ready are both high; valid never depends combinationally on ready, and a
// source holding valid keeps its data stable until that transfer cycle.
module io_mmio_ctrl
  import io_mmio_pkg::*;
#(
  parameter logic [3:0] IO_BASE       = IO_BASE_DEFAULT,
  parameter int         RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic [3:0]  io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output tx_state_e   dbg_tx_state_o
);

  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_mmio_ctrl: RX_FIFO_DEPTH must be a power of 2 and >= 2");
  end

  // Address decode.
  logic       sel, rd_en, tx_wr, clr_wr, rx_pop;
  logic [7:0] ofs;
  assign sel    = (io_addr[31:28] == IO_BASE);
  assign ofs    = io_addr[7:0];
  assign rd_en  = io_re && sel;
  assign tx_wr  = sel && io_we[0] && (ofs == OFS_TXD);
  assign clr_wr = sel && (|io_we) && (ofs == OFS_CLR);
  assign rx_pop = rd_en && (ofs == OFS_RXD);

  logic unused_bits;
  assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

  // ---------------- TX handshake FSM ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_free;

  assign uart_tx_valid  = (tx_state_q == TX_PEND);
  assign uart_tx_data   = tx_data_q;
  assign tx_free        = !uart_tx_valid;
  assign dbg_tx_state_o = tx_state_q;

  // TX next state: load on a write while idle, release after the handshake.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: if (tx_wr) begin
        tx_state_d = TX_PEND;
        tx_data_d  = io_wdata[7:0];
      end
      TX_PEND: if (uart_tx_ready) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state register; reset drops any pending byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // ---------------- RX buffer ----------------
  logic       rx_avail;
  logic [7:0] rx_byte;

`ifdef IO_RX_FIFO_EN
  logic                            fifo_full, fifo_empty;
  logic [$clog2(RX_FIFO_DEPTH):0]  fifo_count;
  logic                            unused_fifo_count;

  io_sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_rx_valid),
    .wdata_i (uart_rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_byte),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign uart_rx_ready     = !fifo_full;
  assign rx_avail          = !fifo_empty;
  assign unused_fifo_count = ^fifo_count;
`else
  logic       rx_avail_q, rx_avail_d;
  logic [7:0] rx_data_q, rx_data_d;

  assign uart_rx_ready = !rx_avail_q;
  assign rx_avail      = rx_avail_q;
  assign rx_byte       = rx_data_q;

  // Holding register: capture when empty, clear on a pop.
  always_comb begin
    rx_avail_d = rx_avail_q;
    rx_data_d  = rx_data_q;
    if (uart_rx_valid && uart_rx_ready) begin
      rx_avail_d = 1'b1;
      rx_data_d  = uart_rx_data;
    end else if (rx_pop) begin
      rx_avail_d = 1'b0;
    end
  end

  // Holding register state; reset discards the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_avail_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_avail_q <= rx_avail_d;
      rx_data_q  <= rx_data_d;
    end
  end
`endif

  // ---------------- Counters ----------------
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  // Counter next values: clear wins over increment; both wrap naturally.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q + {31'b0, inst_retire};
    if (clr_wr) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // ---------------- Read path ----------------
  logic [31:0] rd_val, rdata_q, rdata_d;

  // Read mux over pre-update state; write-only and unmapped offsets read 0.
  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_STATUS: begin
        rd_val[STAT_TX_FREE]  = tx_free;
        rd_val[STAT_RX_AVAIL] = rx_avail;
      end
      OFS_RXD:  rd_val = rx_avail ? {24'b0, rx_byte} : 32'b0;
      OFS_CYC:  rd_val = cycle_cnt_q;
      OFS_INST: rd_val = instr_cnt_q;
      default:  rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  // Load data register: updates only on a selected load, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed testbench for io_mmio_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that acts.
// Build with IO_RX_FIFO_EN defined to exercise the RX FIFO variant.
module tb_io_mmio_ctrl;
  import io_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_addr = '0;
  logic        io_re = 1'b0;
  logic [3:0]  io_we = '0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        inst_retire = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  tx_state_e   dbg_tx_state;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RXD    = 32'h8000_0004;
  localparam logic [31:0] A_TXD    = 32'h8000_0008;
  localparam logic [31:0] A_CYC    = 32'h8000_0010;
  localparam logic [31:0] A_INST   = 32'h8000_0014;
  localparam logic [31:0] A_CLR    = 32'h8000_0018;

  io_mmio_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .io_addr        (io_addr),
    .io_re          (io_re),
    .io_we          (io_we),
    .io_wdata       (io_wdata),
    .io_rdata       (io_rdata),
    .inst_retire    (inst_retire),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_ready  (uart_rx_ready),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_ready  (uart_tx_ready),
    .dbg_tx_state_o (dbg_tx_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load: present address for one cycle, return the registered data.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_addr = a;
    io_re   = 1'b1;
    @(negedge clk);
    d     = io_rdata;
    io_re = 1'b0;
  endtask

  task automatic rdc(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  // Store with byte-0 enable for one cycle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 4'h1;
    @(negedge clk);
    io_we = 4'h0;
  endtask

  // Offer one RX byte for one cycle.
  task automatic rx_push(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    check("rst_fsm", {31'b0, dbg_tx_state}, {31'b0, TX_IDLE});
    rdc("rst_status", A_STATUS, 32'h1);
    rdc("rst_cycle", A_CYC, 32'h1);
    rdc("unmapped_0c", 32'h8000_000C, 32'h0);
    rdc("wo_txd_reads0", A_TXD, 32'h0);
    // Out-of-space load leaves the previous data in place.
    io_rdata_hold_probe();

    // ---- TX ----
    uart_tx_ready = 1'b0;
    wr(A_TXD, 32'h0000_0041);
    check("tx_valid_set", {31'b0, uart_tx_valid}, 32'h1);
    check("tx_data_set", {24'b0, uart_tx_data}, 32'h41);
    check("tx_fsm_pend", {31'b0, dbg_tx_state}, {31'b0, TX_PEND});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tx_hold_valid", {31'b0, uart_tx_valid}, 32'h1);
      check("tx_hold_data", {24'b0, uart_tx_data}, 32'h41);
    end
    rdc("tx_busy_status", A_STATUS, 32'h0);
    wr(A_TXD, 32'h0000_0042);
    check("tx_drop_data", {24'b0, uart_tx_data}, 32'h41);
    check("tx_drop_valid", {31'b0, uart_tx_valid}, 32'h1);
    uart_tx_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (uart_tx_valid) begin
        hs_cnt++;
        check("tx_hs_data", {24'b0, uart_tx_data}, 32'h41);
      end
      @(negedge clk);
    end
    uart_tx_ready = 1'b0;
    check("tx_hs_count", hs_cnt, 32'd1);
    check("tx_valid_clr", {31'b0, uart_tx_valid}, 32'h0);
    rdc("tx_free_status", A_STATUS, 32'h1);

    // ---- RX ----
    rx_push(8'h5A);
    rdc("rx_avail_status", A_STATUS, 32'h3);
`ifndef IO_RX_FIFO_EN
    check("rx_ready_full", {31'b0, uart_rx_ready}, 32'h0);
    rx_push(8'h77);
    check("rx_ready_still_full", {31'b0, uart_rx_ready}, 32'h0);
`endif
    rdc("rx_pop", A_RXD, 32'h5A);
    rdc("rx_pop_empty", A_RXD, 32'h0);
    check("rx_ready_empty", {31'b0, uart_rx_ready}, 32'h1);
    rdc("rx_empty_status", A_STATUS, 32'h1);

`ifdef IO_RX_FIFO_EN
    // ---- RX FIFO ----
    for (int i = 0; i < 9; i++) rx_push(8'(i));
    check("fifo_full_ready", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_data  = 8'hEE;
    uart_rx_valid = 1'b1;
    rdc("fifo_full_pushpop", A_RXD, 32'h0);
    uart_rx_data = 8'h08;
    rdc("fifo_pushpop", A_RXD, 32'h1);
    uart_rx_valid = 1'b0;
    check("fifo_count_kept", {31'b0, uart_rx_ready}, 32'h1);
    for (int i = 2; i <= 8; i++) rdc("fifo_drain", A_RXD, 32'(i));
    rdc("fifo_drained", A_RXD, 32'h0);
    rdc("fifo_empty_status", A_STATUS, 32'h1);
`endif

    // ---- counters ----
    wr(A_CLR, 32'h0);
    rdc("cyc_after_clr", A_CYC, 32'h0);
    for (int i = 0; i < 3; i++) begin
      inst_retire = 1'b1;
      @(negedge clk);
      inst_retire = 1'b0;
      @(negedge clk);
    end
    rdc("instr_3", A_INST, 32'd3);
    inst_retire = 1'b1;
    wr(A_CLR, 32'h0);
    inst_retire = 1'b0;
    rdc("instr_clr_prio", A_INST, 32'h0);
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    io_addr = A_CYC;
    io_re   = 1'b1;
    @(negedge clk);
    check("cyc_max", io_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    check("cyc_wrap", io_rdata, 32'h0);
    io_re = 1'b0;

    // ---- mid-operation reset ----
    wr(A_TXD, 32'h0000_0033);
    rx_push(8'h11);
    check("pre_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("mid_rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    check("mid_rst_rdata", io_rdata, 32'h0);
    rdc("mid_rst_status", A_STATUS, 32'h1);
    rdc("mid_rst_rx_gone", A_RXD, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Load a known value, then issue a load outside the IO space and confirm
  // the output register kept it.
  task automatic io_rdata_hold_probe();
    logic [31:0] d;
    rd(A_STATUS, d);
    rd(32'h4000_0010, d);
    check("unsel_hold", d, 32'h1);
  endtask

endmodule
